// File: rtl/sid_env_pkg.sv
// sid_env_pkg -- shared definitions for the multi-channel SID envelope slice.
//   * one-hot stage encodings (ATT / DEC_SUS / REL)
//   * SID register layout: per-voice stride and control/AD/SR offsets
//   * cntMaxOf : rate nibble -> prescaler reload value
//   * divMaxOf : envelope level -> exponential divider reload (breakpoints)
//   * seqState_t : sweep sequencer states
package sid_env_pkg;

  localparam logic [2:0] ATT     = 3'b001;
  localparam logic [2:0] DEC_SUS = 3'b010;
  localparam logic [2:0] REL     = 3'b100;

  localparam int VOICE_STRIDE = 7;
  localparam int REG_CTRL     = 4;
  localparam int REG_AD       = 5;
  localparam int REG_SR       = 6;

  localparam int CNT_W = 15;
  localparam int DIV_W = 5;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_BUSY
  } seqState_t;

  // Sweeps between envelope ticks minus one, indexed by the 4-bit rate.
  function automatic logic [CNT_W-1:0] cntMaxOf(input logic [3:0] rate);
    case (rate)
      4'h0:    return 15'd8;
      4'h1:    return 15'd31;
      4'h2:    return 15'd62;
      4'h3:    return 15'd94;
      4'h4:    return 15'd148;
      4'h5:    return 15'd219;
      4'h6:    return 15'd266;
      4'h7:    return 15'd312;
      4'h8:    return 15'd391;
      4'h9:    return 15'd976;
      4'hA:    return 15'd1953;
      4'hB:    return 15'd3125;
      4'hC:    return 15'd3906;
      4'hD:    return 15'd11719;
      4'hE:    return 15'd19531;
      default: return 15'd31250;
    endcase
  endfunction

  // Piecewise-exponential slope: the divider reload changes only when the
  // envelope crosses one of the breakpoint levels, otherwise it is kept.
  function automatic logic [DIV_W-1:0] divMaxOf(input logic [7:0]       env,
                                                input logic [DIV_W-1:0] cur);
    case (env)
      8'hFF:   return 5'd0;
      8'h5D:   return 5'd1;
      8'h36:   return 5'd3;
      8'h1A:   return 5'd7;
      8'h0E:   return 5'd15;
      8'h06:   return 5'd29;
      8'h00:   return 5'd0;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/sid_env_mc_if.sv
// sid_env_mc_if -- register bus between the CPU side and sid_env_mc.
//   iWE    write strobe, sampled on posedge clk
//   iAddr  register address (ADDR_W bits)
//   iData  write data
//   oData  registered envelope readback (ENV3-style)
// Modports: master (bus owner / CPU side), slave (envelope block).
interface sid_env_mc_if #(
  parameter int ADDR_W = 5
);
  logic              iWE;
  logic [ADDR_W-1:0] iAddr;
  logic [7:0]        iData;
  logic [7:0]        oData;

  modport master (output iWE, iAddr, iData, input oData);
  modport slave  (input iWE, iAddr, iData, output oData);
endinterface

// File: rtl/sid_env_step.sv
// sid_env_step -- combinational next state of one envelope voice.
// Inputs : env, stage, cnt, div, divMax (current voice state),
//          gate, att, dec, sus, rel (current voice registers).
// Outputs: envN, stageN, cntN, divN, divMaxN (state after this step).
// Build option: SID_ENV_EXP_EN enables the exponential divMax breakpoints;
// without it divMaxN is 0 and decay/release are linear.
module sid_env_step
  import sid_env_pkg::*;
(
  input  logic [7:0]       env,
  input  logic [2:0]       stage,
  input  logic [CNT_W-1:0] cnt,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] divMax,
  input  logic             gate,
  input  logic [3:0]       att,
  input  logic [3:0]       dec,
  input  logic [3:0]       sus,
  input  logic [3:0]       rel,
  output logic [7:0]       envN,
  output logic [2:0]       stageN,
  output logic [CNT_W-1:0] cntN,
  output logic [DIV_W-1:0] divN,
  output logic [DIV_W-1:0] divMaxN
);

  logic [3:0] rate;
  logic       tick;
  logic       divZero;
  logic       divTick;

  always_comb begin
    rate = att;
    if (stage == DEC_SUS)
      rate = dec;
    else if (stage == REL)
      rate = rel;

    tick    = (cnt == '0);
    divZero = (div == '0);
    divTick = tick & divZero;

    cntN = tick ? cntMaxOf(rate) : cnt - 1'b1;
    divN = div;
    if (tick)
      divN = divZero ? divMax : div - 1'b1;

    // A stage change always wins over an envelope update in the same step.
    envN   = env;
    stageN = stage;
    case (stage)
      ATT: begin
        if (!gate)
          stageN = REL;
        else if (env == 8'hFF)
          stageN = DEC_SUS;
        else if (tick)
          envN = env + 1'b1;
      end
      DEC_SUS: begin
        if (!gate)
          stageN = REL;
        else if (divTick && (env > {sus, sus}))
          envN = env - 1'b1;
      end
      default: begin
        // REL, and recovery from any non one-hot encoding.
        stageN = gate ? ATT : REL;
        if (!gate && divTick && (env != 8'h00))
          envN = env - 1'b1;
      end
    endcase

`ifdef SID_ENV_EXP_EN
    divMaxN = divMaxOf(env, divMax);
`else
    divMaxN = '0;
`endif
  end

endmodule

// File: rtl/sid_env_mc.sv
// sid_env_mc -- time-multiplexed SID ADSR envelope generator for CHANNELS
// voices. A clkEn strobe starts a sweep that steps voice 0..CHANNELS-1 on
// consecutive clocks through one shared sid_env_step datapath.
// Ports:
//   clk       master clock
//   iRstN     asynchronous active-low reset
//   clkEn     1 MHz sweep strobe (one clk wide)
//   bus       sid_env_mc_if.slave: iWE/iAddr/iData writes, oData readback
//   oOut      packed envelopes, voice i at [8i+7:8i]
//   oDone     one-cycle pulse after the last voice step of a sweep
//   oOverrun  sticky flag: clkEn seen while a sweep was still running
// Build option: SID_ENV_EXP_EN selects exponential decay/release slopes.
module sid_env_mc
  import sid_env_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 5,
  parameter int READBACK_CH = 2
) (
  input  logic                  clk,
  input  logic                  iRstN,
  input  logic                  clkEn,
  sid_env_mc_if.slave           bus,
  output logic [8*CHANNELS-1:0] oOut,
  output logic                  oDone,
  output logic                  oOverrun
);

  localparam int             IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  function automatic logic [ADDR_W-1:0] voiceAddr(input int v, input int off);
    return ADDR_W'(BASE_ADDR + VOICE_STRIDE * v + off);
  endfunction

  // Voice registers
  logic [CHANNELS-1:0] gate;
  logic [3:0]          att [CHANNELS];
  logic [3:0]          dec [CHANNELS];
  logic [3:0]          sus [CHANNELS];
  logic [3:0]          rel [CHANNELS];

  // Voice envelope state
  logic [7:0]       envArr    [CHANNELS];
  logic [2:0]       stageArr  [CHANNELS];
  logic [CNT_W-1:0] cntArr    [CHANNELS];
  logic [DIV_W-1:0] divArr    [CHANNELS];
  logic [DIV_W-1:0] divMaxArr [CHANNELS];

  // Sequencer
  seqState_t        state, stateN;
  logic [IDX_W-1:0] idx, idxN;
  logic             stepEn;
  logic             lastStep;
  logic             overrunN;

  // Step datapath results
  logic [7:0]       envN;
  logic [2:0]       stageN;
  logic [CNT_W-1:0] cntN;
  logic [DIV_W-1:0] divN;
  logic [DIV_W-1:0] divMaxN;

  always_comb begin
    stateN   = state;
    idxN     = idx;
    stepEn   = 1'b0;
    lastStep = 1'b0;
    overrunN = oOverrun;
    case (state)
      SEQ_IDLE: begin
        if (clkEn) begin
          stateN = SEQ_BUSY;
          idxN   = '0;
        end
      end
      SEQ_BUSY: begin
        stepEn = 1'b1;
        if (clkEn)
          overrunN = 1'b1;
        if (idx == LAST_IDX) begin
          stateN   = SEQ_IDLE;
          idxN     = '0;
          lastStep = 1'b1;
        end else begin
          idxN = idx + 1'b1;
        end
      end
      default: begin
        stateN = SEQ_IDLE;
        idxN   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= SEQ_IDLE;
      idx      <= '0;
      oDone    <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      state    <= stateN;
      idx      <= idxN;
      oDone    <= lastStep;
      oOverrun <= overrunN;
    end
  end

  // Register writes land on the same edge as a step, so a voice stepped in
  // the write cycle still sees the old value; the new one applies next sweep.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      gate <= '0;
      for (int v = 0; v < CHANNELS; v++) begin
        att[v] <= '0;
        dec[v] <= '0;
        sus[v] <= '0;
        rel[v] <= '0;
      end
    end else if (bus.iWE) begin
      for (int v = 0; v < CHANNELS; v++) begin
        if (bus.iAddr == voiceAddr(v, REG_CTRL))
          gate[v] <= bus.iData[0];
        if (bus.iAddr == voiceAddr(v, REG_AD)) begin
          att[v] <= bus.iData[7:4];
          dec[v] <= bus.iData[3:0];
        end
        if (bus.iAddr == voiceAddr(v, REG_SR)) begin
          sus[v] <= bus.iData[7:4];
          rel[v] <= bus.iData[3:0];
        end
      end
    end
  end

  sid_env_step uStep (
    .env     (envArr[idx]),
    .stage   (stageArr[idx]),
    .cnt     (cntArr[idx]),
    .div     (divArr[idx]),
    .divMax  (divMaxArr[idx]),
    .gate    (gate[idx]),
    .att     (att[idx]),
    .dec     (dec[idx]),
    .sus     (sus[idx]),
    .rel     (rel[idx]),
    .envN    (envN),
    .stageN  (stageN),
    .cntN    (cntN),
    .divN    (divN),
    .divMaxN (divMaxN)
  );

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      for (int v = 0; v < CHANNELS; v++) begin
        envArr[v]    <= '0;
        stageArr[v]  <= REL;
        cntArr[v]    <= '0;
        divArr[v]    <= '0;
        divMaxArr[v] <= '0;
      end
    end else if (stepEn) begin
      envArr[idx]    <= envN;
      stageArr[idx]  <= stageN;
      cntArr[idx]    <= cntN;
      divArr[idx]    <= divN;
      divMaxArr[idx] <= divMaxN;
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN)
      bus.oData <= '0;
    else
      bus.oData <= envArr[READBACK_CH];
  end

  for (genvar v = 0; v < CHANNELS; v++) begin : gOut
    assign oOut[8*v +: 8] = envArr[v];
  end

endmodule

// File: doc/sid_env_mc.md
Name: sid_env_mc

Overview:
- Parametrised, time-multiplexed multi-channel SID ADSR envelope generator; successor to the single-voice envelope block.
- One shared step datapath serves CHANNELS voices; per-voice state lives in register arrays.
- Decodes SID-layout voice registers (7-byte stride) from the shared bus. Drives packed 8-bit envelopes to the voice multipliers and an ENV3-style readback.

Parameters:
- CHANNELS, 3, voice count, 1..4; requires clk/clkEn ratio >= CHANNELS+1.
- BASE_ADDR, 0, address of voice 0 register 0.
- ADDR_W, 5, bus address width; BASE_ADDR+7*(CHANNELS-1)+6 < 2**ADDR_W.
- READBACK_CH, 2, voice mirrored on oData.

Ports:
- clk  in  1  master clock.
- iRstN  in  1  asynchronous active-low reset.
- clkEn  in  1  1 MHz sweep strobe, one clk wide.
- iWE  in  1  write enable, sampled on posedge clk.
- iAddr  in  ADDR_W  address bus.
- iData  in  8  data bus.
- oOut  out  8*CHANNELS  envelope of voice i at [8i+7:8i].
- oData  out  8  registered envelope of READBACK_CH.
- oDone  out  1  one-cycle pulse after the last voice step of a sweep.
- oOverrun  out  1  sticky: clkEn arrived while a sweep was busy.

Behaviour:
- Reset (async, iRstN=0): all env=0, stage=REL, cnt=0, div=0, divMax=0, gate/att/dec/sus/rel=0, sequencer idle; oOut=0, oData=0, oDone=0, oOverrun=0.
- Register decode, voice v at A=BASE_ADDR+7v:
  - A+4 bit0 -> gate.
  - A+5 -> att=[7:4], dec=[3:0].
  - A+6 -> sus=[7:4], rel=[3:0].
  - Other addresses are ignored.
- Sequencer:
  - Idle + clkEn: busy, idx=0.
  - Each busy clk steps voice idx, then idx+1.
  - After stepping idx=CHANNELS-1: idle, oDone=1 on the next cycle.
  - clkEn while busy: ignored, oOverrun<=1.
- Per-voice step, using values registered before the step; a write in the same cycle takes effect next sweep:
  - rate = att (ATT), dec (DEC_SUS), rel (REL).
  - cntMax table: 8,31,62,94,148,219,266,312,391,976,1953,3125,3906,11719,19531,31250 for rate 0..F.
  - tick=(cnt==0). If tick, cnt<=cntMax, else cnt<=cnt-1.
  - If tick: divTick=(div==0); div<=divTick ? divMax : div-1.
  - ATT: gate=0 -> REL. env==FF -> DEC_SUS, no increment. Else tick -> env+1.
  - DEC_SUS: gate=0 -> REL. Else on divTick: if env>{sus,sus} then env-1, else hold. Raising sus above env never increments env.
  - REL: gate=1 -> ATT. Else on divTick: env-1, saturating at 0.
  - Stage change and env update are never applied in the same step.
- divMax is updated in the step, from the pre-step env: FF->0, 5D->1, 36->3, 1A->7, 0E->15, 06->29, 00->0; other values hold.
- oOut slice idx updates on the step cycle's clock edge. oData follows env[READBACK_CH] one clk later.
- Gate toggled twice within one sweep period: only the level at step time matters.

Optional Feature:
- Macro SID_ENV_EXP_EN.
- Defined: exponential divMax breakpoints as above.
- Undefined: divMax is tied to 0, giving linear decay/release (divTick==tick); the breakpoint logic is not synthesised.

Decomposition:
- Package sid_env_pkg:
  - stage one-hot localparams ATT=1, DEC_SUS=2, REL=4;
  - 16-entry cntMax table function;
  - breakpoint function env->divMax;
  - register offsets 4/5/6 and stride 7.
- Sub-module sid_env_step: combinational next-state for one voice (env, stage, cnt, div, divMax in/out); the top holds the arrays, sequencer and decoder.

Test Plan:
- Reset mid-sweep (iRstN low for 1 clk at idx=1) -> all oOut=0, oDone absent, oOverrun=0, sequencer idle.
- Voice 0: att=0, gate=1 -> env=01 after sweep 1; env=FF after sweep 2287; stage DEC_SUS at sweep 2288; other voices stay 00.
- Voice 1: att=0, dec=0, sus=8 -> attacks to FF, then decays and holds at 88; a later write sus=F leaves env at 88.
- Voice 2 at env=05 in REL, rel=0, with SID_ENV_EXP_EN -> decrements every 9*30=270 sweeps; without the macro, every 9 sweeps; holds at 00; oData tracks oOut[23:16].
- Two clkEn pulses 2 clk apart with CHANNELS=3 -> oOverrun=1 (sticky); single sweep executed; oDone pulses once.
- Write to BASE_ADDR+7+4 (gate) in the cycle voice 1 is stepped -> voice 1 stays in REL that sweep, enters ATT next sweep.
